// File: rtl/morse_tx_pkg.sv
// Shared definitions for the Morse link: unit multiples, FSM state encoding
// and the code-table entry layout used by both the transmitter and the decoder.
package morse_tx_pkg;

  localparam int DOT_U  = 1;
  localparam int DASH_U = 3;
  localparam int EGAP_U = 1;
  localparam int CGAP_U = 3;
  localparam int WGAP_U = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MARK,
    ST_ELEM_GAP,
    ST_CHAR_GAP
  } state_e;

  // pat is right-aligned: the first element sent is pat[len-1], 1 = dash.
  // len == 0 on a valid entry marks the word space.
  typedef struct packed {
    logic       valid;
    logic [2:0] len;
    logic [4:0] pat;
  } code_t;

  function automatic code_t mk_code(input logic [2:0] len, input logic [4:0] pat);
    code_t c;
    c.valid = 1'b1;
    c.len   = len;
    c.pat   = pat;
    return c;
  endfunction

endpackage

// File: rtl/morse_tx_code_rom.sv
// Combinational ASCII -> Morse code lookup; lower case folds onto upper case.
module morse_tx_code_rom
  import morse_tx_pkg::*;
(
  input  logic [7:0] char_i,
  output code_t      code_o
);

  logic [7:0] ch_up;

  assign ch_up = (char_i >= 8'h61 && char_i <= 8'h7a) ? char_i - 8'h20 : char_i;

  always_comb begin
    code_o = '0;
    case (ch_up)
      8'h20: code_o = mk_code(3'd0, 5'b00000);
      "A":   code_o = mk_code(3'd2, 5'b00001);
      "B":   code_o = mk_code(3'd4, 5'b01000);
      "C":   code_o = mk_code(3'd4, 5'b01010);
      "D":   code_o = mk_code(3'd3, 5'b00100);
      "E":   code_o = mk_code(3'd1, 5'b00000);
      "F":   code_o = mk_code(3'd4, 5'b00010);
      "G":   code_o = mk_code(3'd3, 5'b00110);
      "H":   code_o = mk_code(3'd4, 5'b00000);
      "I":   code_o = mk_code(3'd2, 5'b00000);
      "J":   code_o = mk_code(3'd4, 5'b00111);
      "K":   code_o = mk_code(3'd3, 5'b00101);
      "L":   code_o = mk_code(3'd4, 5'b00100);
      "M":   code_o = mk_code(3'd2, 5'b00011);
      "N":   code_o = mk_code(3'd2, 5'b00010);
      "O":   code_o = mk_code(3'd3, 5'b00111);
      "P":   code_o = mk_code(3'd4, 5'b00110);
      "Q":   code_o = mk_code(3'd4, 5'b01101);
      "R":   code_o = mk_code(3'd3, 5'b00010);
      "S":   code_o = mk_code(3'd3, 5'b00000);
      "T":   code_o = mk_code(3'd1, 5'b00001);
      "U":   code_o = mk_code(3'd3, 5'b00001);
      "V":   code_o = mk_code(3'd4, 5'b00001);
      "W":   code_o = mk_code(3'd3, 5'b00011);
      "X":   code_o = mk_code(3'd4, 5'b01001);
      "Y":   code_o = mk_code(3'd4, 5'b01011);
      "Z":   code_o = mk_code(3'd4, 5'b01100);
      "0":   code_o = mk_code(3'd5, 5'b11111);
      "1":   code_o = mk_code(3'd5, 5'b01111);
      "2":   code_o = mk_code(3'd5, 5'b00111);
      "3":   code_o = mk_code(3'd5, 5'b00011);
      "4":   code_o = mk_code(3'd5, 5'b00001);
      "5":   code_o = mk_code(3'd5, 5'b00000);
      "6":   code_o = mk_code(3'd5, 5'b10000);
      "7":   code_o = mk_code(3'd5, 5'b11000);
      "8":   code_o = mk_code(3'd5, 5'b11100);
      "9":   code_o = mk_code(3'd5, 5'b11110);
      default: code_o = '0;
    endcase
  end

endmodule

// File: rtl/morse_tx.sv
// Morse transmitter: one character per start/ready handshake onto a keyed line.
//   state       | meaning
//   ST_IDLE     | ready=1, waiting for start
//   ST_MARK     | key down for a dot or dash
//   ST_ELEM_GAP | 1U space between elements
//   ST_CHAR_GAP | 3U trailing space (7U for a word space)
module morse_tx
  import morse_tx_pkg::*;
#(
  parameter int UNIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] char_in,
  input  logic       start,
  output logic       ready,
  output logic       out,
  output logic       done,
  output logic       err
);

  localparam int CW = $clog2(7 * UNIT_CYCLES + 1);
  localparam logic [CW-1:0] DOT_CNT  = CW'(DOT_U * UNIT_CYCLES);
  localparam logic [CW-1:0] DASH_CNT = CW'(DASH_U * UNIT_CYCLES);
  localparam logic [CW-1:0] EGAP_CNT = CW'(EGAP_U * UNIT_CYCLES);
  localparam logic [CW-1:0] CGAP_CNT = CW'(CGAP_U * UNIT_CYCLES);
  localparam logic [CW-1:0] WGAP_CNT = CW'(WGAP_U * UNIT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  code_t          rom_code;
  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [2:0]     idx_q;
  logic [4:0]     pat_q;
  logic           out_q, ready_q, done_q, err_q;
  logic [CW-1:0]  first_cnt_d, next_cnt_d;

  morse_tx_code_rom u_rom (
    .char_i (char_in),
    .code_o (rom_code)
  );

  // Mark lengths for the first element of a new character and for the
  // element that follows the current intra-character gap.
  always_comb begin
    first_cnt_d = rom_code.pat[rom_code.len - 3'd1] ? DASH_CNT : DOT_CNT;
    next_cnt_d  = pat_q[idx_q] ? DASH_CNT : DOT_CNT;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      pat_q   <= '0;
      out_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (!rom_code.valid) begin
              err_q <= 1'b1;
            end else if (rom_code.len == 3'd0) begin
              state_q <= ST_CHAR_GAP;
              cnt_q   <= WGAP_CNT;
              ready_q <= 1'b0;
            end else begin
              state_q <= ST_MARK;
              cnt_q   <= first_cnt_d;
              idx_q   <= rom_code.len - 3'd1;
              pat_q   <= rom_code.pat;
              out_q   <= 1'b1;
              ready_q <= 1'b0;
            end
          end
        end
        ST_MARK: begin
          if (cnt_q == CNT_LAST) begin
            out_q <= 1'b0;
            if (idx_q == 3'd0) begin
              state_q <= ST_CHAR_GAP;
              cnt_q   <= CGAP_CNT;
            end else begin
              state_q <= ST_ELEM_GAP;
              cnt_q   <= EGAP_CNT;
              idx_q   <= idx_q - 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - CNT_LAST;
          end
        end
        ST_ELEM_GAP: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_MARK;
            cnt_q   <= next_cnt_d;
            out_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_LAST;
          end
        end
        ST_CHAR_GAP: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_LAST;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready = ready_q;
  assign out   = out_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_morse_tx.sv
// Scoreboard bench for morse_tx: expected key waveforms are queued per
// character and checked by a monitor when done/err appears.
module tb_morse_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] char2 = 8'h00, char1 = 8'h00;
  logic       start2 = 1'b0, start1 = 1'b0;
  logic       ready2, out2, done2, err2;
  logic       ready1, out1, done1, err1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit    is_err;
    string wave;
  } exp_t;

  exp_t  q0[$];
  exp_t  q1[$];
  string cap[2];
  bit    busy[2];

  morse_tx #(.UNIT_CYCLES(2)) u_dut2 (
    .clk(clk), .reset(rst_n), .char_in(char2), .start(start2),
    .ready(ready2), .out(out2), .done(done2), .err(err2)
  );

  morse_tx #(.UNIT_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(rst_n), .char_in(char1), .start(start1),
    .ready(ready1), .out(out1), .done(done1), .err(err1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic string wave(string m, int u);
    string w = "";
    if (m == " ") begin
      for (int i = 0; i < 7 * u; i++) w = {w, "0"};
      return w;
    end
    for (int k = 0; k < m.len(); k++) begin
      int n;
      n = (m[k] == "-") ? 3 * u : u;
      for (int i = 0; i < n; i++) w = {w, "1"};
      if (k < m.len() - 1)
        for (int i = 0; i < u; i++) w = {w, "0"};
    end
    for (int i = 0; i < 3 * u; i++) w = {w, "0"};
    return w;
  endfunction

  function automatic int qsize(int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic rd(int d);
    return (d == 0) ? ready2 : ready1;
  endfunction

  function automatic logic dn(int d);
    return (d == 0) ? done2 : done1;
  endfunction

  task automatic push(int d, bit is_err, string w);
    exp_t e;
    e.is_err = is_err;
    e.wave   = w;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic drive(int d, logic [7:0] ch, logic st);
    if (d == 0) begin char2 = ch; start2 = st; end
    else        begin char1 = ch; start1 = st; end
  endtask

  task automatic chk(string name, logic act, logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  // Monitor step for one DUT, run on every falling edge.
  task automatic mon(int d, logic rs, logic st, logic rdy, logic o, logic dnv, logic erv);
    exp_t e;
    bit   ok;
    if (!rs) begin
      busy[d] = 1'b0;
      cap[d]  = "";
      return;
    end
    if (dnv || erv) begin
      checks++;
      if (qsize(d) == 0) begin
        errors++;
        $display("FAIL dut%0d unexpected %s wave=%s required=none", d, erv ? "err" : "done", cap[d]);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        if (e.is_err) ok = erv && !dnv && rdy && !o && (cap[d] == "");
        else          ok = dnv && !erv && rdy && !o && (cap[d] == e.wave);
        if (!ok) begin
          errors++;
          $display("FAIL dut%0d char actual=%s/%s ready=%b required=%s/%s ready=1",
                   d, erv ? "err" : "done", cap[d], rdy, e.is_err ? "err" : "done", e.wave);
        end
      end
      busy[d] = 1'b0;
    end else if (busy[d]) begin
      if (o) cap[d] = {cap[d], "1"};
      else   cap[d] = {cap[d], "0"};
    end
    if (st && rdy) begin
      busy[d] = 1'b1;
      cap[d]  = "";
    end
  endtask

  always @(negedge clk) begin
    mon(0, rst_n, start2, ready2, out2, done2, err2);
    mon(1, rst_n, start1, ready1, out1, done1, err1);
  end

  task automatic issue(int d, logic [7:0] ch);
    @(posedge clk); #1;
    drive(d, ch, 1'b1);
    @(posedge clk); #1;
    drive(d, ch, 1'b0);
  endtask

  task automatic wait_idle(int d, int bound);
    int n = 0;
    while (qsize(d) != 0 || !rd(d)) begin
      @(posedge clk); #1;
      n++;
      if (n > bound) begin
        checks++;
        errors++;
        $display("FAIL dut%0d idle_timeout pending=%0d required=0", d, qsize(d));
        if (d == 0) q0.delete();
        else        q1.delete();
        break;
      end
    end
  endtask

  task automatic wait_done(int d, int bound);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!dn(d) && n <= bound);
    if (!dn(d)) begin
      checks++;
      errors++;
      $display("FAIL dut%0d done_timeout actual=0 required=1", d);
    end
  endtask

  task automatic send(int d, logic [7:0] ch, bit is_err, string w);
    push(d, is_err, w);
    issue(d, ch);
    wait_idle(d, 200);
  endtask

  task automatic b2b(int d, logic [7:0] c1, logic [7:0] c2, string w1, string w2);
    push(d, 1'b0, w1);
    push(d, 1'b0, w2);
    @(posedge clk); #1;
    drive(d, c1, 1'b1);
    wait_done(d, 200);
    drive(d, c2, 1'b1);
    wait_done(d, 200);
    drive(d, c2, 1'b0);
    wait_idle(d, 200);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out2", out2, 1'b0);
    chk("rst_ready2", ready2, 1'b1);
    chk("rst_done2", done2, 1'b0);
    chk("rst_err2", err2, 1'b0);
    chk("rst_out1", out1, 1'b0);
    chk("rst_ready1", ready1, 1'b1);
    chk("rst_done1", done1, 1'b0);
    chk("rst_err1", err1, 1'b0);
    rst_n = 1'b1;

    send(0, "E", 1'b0, "11000000");
    send(0, "A", 1'b0, "1100111111000000");
    send(0, "a", 1'b0, "1100111111000000");
    send(0, "0", 1'b0, wave("-----", 2));
    send(0, " ", 1'b0, "00000000000000");
    send(0, "#", 1'b1, "");
    send(0, "q", 1'b0, wave("--.-", 2));
    send(0, "5", 1'b0, wave(".....", 2));
    send(0, 8'h7b, 1'b1, "");

    // Abandon a dash partway through with reset.
    issue(0, "T");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_out", out2, 1'b0);
    chk("midrst_ready", ready2, 1'b1);
    chk("midrst_done", done2, 1'b0);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("postrst_out", out2, 1'b0);
    send(0, "K", 1'b0, wave("-.-", 2));

    // Start pulses while busy must be ignored.
    push(0, 1'b0, "11000000");
    issue(0, "E");
    repeat (2) @(posedge clk);
    #1;
    drive(0, "T", 1'b1);
    @(posedge clk); #1;
    drive(0, "T", 1'b0);
    @(posedge clk); #1;
    drive(0, "M", 1'b1);
    @(posedge clk); #1;
    drive(0, "M", 1'b0);
    wait_idle(0, 200);
    repeat (4) @(posedge clk);

    b2b(0, "S", "O", wave("...", 2), wave("---", 2));

    send(1, "E", 1'b0, "1000");
    b2b(1, "S", "O", wave("...", 1), wave("---", 1));
    send(1, "#", 1'b1, "");
    send(1, " ", 1'b0, "0000000");

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
